// File: rtl/control_sequencer.sv
//------------------------------------------------------------------------------
// control_sequencer -- hardwired fetch/decode/execute strobe sequencer.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        pc_out,
  output logic        pc_increment,
  output logic        mar_in,
  output logic        pc_in,
  output logic        read,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        zlow_in,
  output logic        zhigh_in,
  output logic        zlow_out,
  output logic        zhigh_out,
  output logic        lo_in,
  output logic        hi_in,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic [4:0]  op_code,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_t;

  state_t     state;
  logic [4:0] op_q;
  logic [3:0] ra_q, rb_q, rc_q;
  logic       md_q, bad_q;

  logic [4:0] ir_op;
  logic [3:0] ir_ra, ir_rb, ir_rc;
  logic       ir_alu, ir_md;
  logic       unused_ir;

  assign ir_op     = ir[31:27];
  assign ir_ra     = ir[26:23];
  assign ir_rb     = ir[22:19];
  assign ir_rc     = ir[18:15];
  assign ir_alu    = (ir_op >= 5'b00011) && (ir_op <= 5'b01011);
  assign ir_md     = (ir_op == 5'b01111) || (ir_op == 5'b10000);
  assign unused_ir = ^ir[14:0];

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

  // Outputs are registered with the values belonging to the state being entered.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= IDLE;
      op_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      rc_q         <= '0;
      md_q         <= 1'b0;
      bad_q        <= 1'b0;
      pc_out       <= 1'b0;
      pc_increment <= 1'b0;
      mar_in       <= 1'b0;
      pc_in        <= 1'b0;
      read         <= 1'b0;
      mdr_in       <= 1'b0;
      mdr_out      <= 1'b0;
      ir_in        <= 1'b0;
      y_in         <= 1'b0;
      zlow_in      <= 1'b0;
      zhigh_in     <= 1'b0;
      zlow_out     <= 1'b0;
      zhigh_out    <= 1'b0;
      lo_in        <= 1'b0;
      hi_in        <= 1'b0;
      reg_in       <= '0;
      reg_out      <= '0;
      op_code      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      pc_out       <= 1'b0;
      pc_increment <= 1'b0;
      mar_in       <= 1'b0;
      pc_in        <= 1'b0;
      read         <= 1'b0;
      mdr_in       <= 1'b0;
      mdr_out      <= 1'b0;
      ir_in        <= 1'b0;
      y_in         <= 1'b0;
      zlow_in      <= 1'b0;
      zhigh_in     <= 1'b0;
      zlow_out     <= 1'b0;
      zhigh_out    <= 1'b0;
      lo_in        <= 1'b0;
      hi_in        <= 1'b0;
      reg_in       <= '0;
      reg_out      <= '0;
      op_code      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state        <= T0;
            busy         <= 1'b1;
            pc_out       <= 1'b1;
            pc_increment <= 1'b1;
            mar_in       <= 1'b1;
            zlow_in      <= 1'b1;
            zhigh_in     <= 1'b1;
          end
        end
        T0: begin
          state    <= T1;
          busy     <= 1'b1;
          zlow_out <= 1'b1;
          pc_in    <= 1'b1;
          read     <= 1'b1;
          mdr_in   <= 1'b1;
        end
        T1: begin
          busy <= 1'b1;
          if (mem_ready) begin
            state   <= T2;
            mdr_out <= 1'b1;
            ir_in   <= 1'b1;
          end else begin
            // Stall cycles keep the read going but never reload the PC.
            zlow_out <= 1'b1;
            read     <= 1'b1;
            mdr_in   <= 1'b1;
          end
        end
        T2: begin
          state <= T3;
          busy  <= 1'b1;
          op_q  <= ir_op;
          ra_q  <= ir_ra;
          rb_q  <= ir_rb;
          rc_q  <= ir_rc;
          md_q  <= ir_md;
          bad_q <= !(ir_alu || ir_md);
          if (ir_alu) begin
            reg_out <= onehot(ir_rb);
            y_in    <= 1'b1;
          end else if (ir_md) begin
            reg_out <= onehot(ir_ra);
            y_in    <= 1'b1;
          end else begin
            illegal <= 1'b1;
          end
        end
        T3: begin
          if (bad_q) begin
            state <= IDLE;
          end else begin
            state    <= T4;
            busy     <= 1'b1;
            reg_out  <= onehot(md_q ? rb_q : rc_q);
            zlow_in  <= 1'b1;
            zhigh_in <= 1'b1;
            op_code  <= op_q;
          end
        end
        T4: begin
          state    <= T5;
          busy     <= 1'b1;
          zlow_out <= 1'b1;
          if (md_q) lo_in  <= 1'b1;
          else      reg_in <= onehot(ra_q);
        end
        T5, T6: begin
          if (state == T5 && md_q) begin
            state     <= T6;
            busy      <= 1'b1;
            zhigh_out <= 1'b1;
            hi_in     <= 1'b1;
          end else begin
            done <= 1'b1;
            if (run) begin
              state        <= T0;
              busy         <= 1'b1;
              pc_out       <= 1'b1;
              pc_increment <= 1'b1;
              mar_in       <= 1'b1;
              zlow_in      <= 1'b1;
              zhigh_in     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
//------------------------------------------------------------------------------
// tb_control_sequencer -- scoreboard bench: per-cycle expected strobe vectors.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        run = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] ir = '0;
  logic        pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out, ir_in;
  logic        y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in;
  logic [15:0] reg_in, reg_out;
  logic [4:0]  op_code;
  logic        busy, done, illegal;

  typedef struct packed {
    logic pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out, ir_in;
    logic y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic [4:0]  op_code;
    logic busy, done, illegal;
  } outs_t;

  typedef struct {
    outs_t       o;
    logic        mr;
    logic        rn;
    logic [31:0] irv;
    string       tag;
  } ent_t;

  outs_t act;
  ent_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  logic  pend_done = 1'b0;

  assign act = {pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out, ir_in,
                y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in,
                reg_in, reg_out, op_code, busy, done, illegal};

  control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
    .pc_out(pc_out), .pc_increment(pc_increment), .mar_in(mar_in), .pc_in(pc_in),
    .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
    .zlow_in(zlow_in), .zhigh_in(zhigh_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .lo_in(lo_in), .hi_in(hi_in), .reg_in(reg_in), .reg_out(reg_out),
    .op_code(op_code), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic push(input outs_t o, input logic mr, input logic rn,
                      input logic [31:0] irv, input string tag);
    ent_t e;
    o.done    = pend_done;
    pend_done = 1'b0;
    e.o = o; e.mr = mr; e.rn = rn; e.irv = irv; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input logic rn);
    outs_t v;
    v = '0;
    push(v, 1'b1, rn, 32'h0, "idle");
  endtask

  task automatic push_instr(input logic [31:0] irv, input int stalls,
                            input logic run_mid, input logic run_next);
    outs_t       v;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic [15:0] one;
    logic        alu, md;
    one = 16'h0001;
    op = irv[31:27]; ra = irv[26:23]; rb = irv[22:19]; rc = irv[18:15];
    alu = (op >= 5'd3) && (op <= 5'd11);
    md  = (op == 5'd15) || (op == 5'd16);
    v = '0; v.busy = 1; v.pc_out = 1; v.pc_increment = 1; v.mar_in = 1;
    v.zlow_in = 1; v.zhigh_in = 1;
    push(v, 1'b1, run_mid, irv, "T0");
    for (int i = 0; i <= stalls; i++) begin
      v = '0; v.busy = 1; v.zlow_out = 1; v.read = 1; v.mdr_in = 1; v.pc_in = (i == 0);
      push(v, (i == stalls), run_mid, irv, "T1");
    end
    v = '0; v.busy = 1; v.mdr_out = 1; v.ir_in = 1;
    push(v, 1'b1, run_mid, irv, "T2");
    if (alu || md) begin
      v = '0; v.busy = 1; v.y_in = 1; v.reg_out = one << (alu ? rb : ra);
      push(v, 1'b1, run_mid, irv, "T3");
      v = '0; v.busy = 1; v.zlow_in = 1; v.zhigh_in = 1; v.op_code = op;
      v.reg_out = one << (alu ? rc : rb);
      push(v, 1'b1, run_mid, irv, "T4");
      v = '0; v.busy = 1; v.zlow_out = 1;
      if (alu) v.reg_in = one << ra;
      else     v.lo_in = 1;
      push(v, 1'b1, alu ? run_next : run_mid, irv, "T5");
      if (md) begin
        v = '0; v.busy = 1; v.zhigh_out = 1; v.hi_in = 1;
        push(v, 1'b1, run_next, irv, "T6");
      end
      pend_done = 1'b1;
    end else begin
      v = '0; v.busy = 1; v.illegal = 1;
      push(v, 1'b1, run_next, irv, "T3ill");
    end
  endtask

  task automatic step();
    ent_t e;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(e.tag, 64'(act), 64'(e.o));
    mem_ready = e.mr;
    run       = e.rn;
    ir        = e.irv;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      step();
      guard++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rir;
    logic [4:0]  bad_ops [6];
    bad_ops = '{5'b11111, 5'b00010, 5'b01100, 5'b00000, 5'b01110, 5'b10001};

    #1 clr = 1'b0;
    #1 chk("reset", 64'(act), 64'h0);
    #10 clr = 1'b1;

    // shl r4 <- r3, r9
    push_idle(1'b1);
    push_instr(32'h5A1C8000, 0, 1'b1, 1'b0);
    push_idle(1'b0);
    drain();

    // add with 3-cycle memory stall; run dropped mid-instruction
    push_idle(1'b1);
    push_instr({5'b00011, 4'd7, 4'd1, 4'd14, 15'd0}, 3, 1'b0, 1'b0);
    push_idle(1'b0);
    drain();

    // mul and div
    push_idle(1'b1);
    push_instr(32'h79100000, 0, 1'b1, 1'b0);
    push_idle(1'b0);
    push_idle(1'b1);
    push_instr({5'b10000, 4'd5, 4'd9, 4'd0, 15'h7FFF}, 1, 1'b1, 1'b0);
    push_idle(1'b0);
    drain();

    // illegal opcodes, including those adjacent to the legal ranges
    for (int i = 0; i < 6; i++) begin
      push_idle(1'b1);
      push_instr({bad_ops[i], 4'd15, 4'd15, 4'd15, 15'd0}, 0, 1'b1, 1'b0);
      push_idle(1'b0);
    end
    drain();

    // back-to-back adds, then a random ALU chain with run held high
    push_idle(1'b1);
    push_instr({5'b00011, 4'd0, 4'd15, 4'd8, 15'd0}, 0, 1'b1, 1'b1);
    push_instr({5'b00011, 4'd15, 4'd0, 4'd1, 15'd0}, 0, 1'b1, 1'b0);
    push_idle(1'b0);
    push_idle(1'b1);
    for (int i = 0; i < 6; i++) begin
      rir = $urandom;
      rir[31:27] = 5'($urandom_range(3, 11));
      push_instr(rir, i % 2, 1'b1, (i != 5));
    end
    push_idle(1'b0);
    drain();

    // asynchronous reset while in T4, then restart
    push_idle(1'b1);
    push_instr({5'b00100, 4'd3, 4'd6, 4'd12, 15'd0}, 0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step();
    clr = 1'b0;
    #1 chk("rst_t4", 64'(act), 64'h0);
    exp_q.delete();
    pend_done = 1'b0;
    run = 1'b1;
    #2 clr = 1'b1;
    push_instr({5'b01010, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1'b1, 1'b0);
    push_idle(1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
